// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver.
// Frame-latched BCD digits, active-low anode/segment outputs, field blink.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] minutes_tens,
  input  logic [3:0] minutes_units,
  input  logic [3:0] seconds_tens,
  input  logic [3:0] seconds_units,
  input  logic       blink_en,
  input  logic       blink_sel,
  output logic [3:0] anode,
  output logic [6:0] segments
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_TICKS - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0][3:0]   shadow_q, shadow_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic [3:0]        anode_q, anode_d;
  logic [6:0]        seg_q, seg_d;
  logic              tick;
  logic [3:0]        digit;
  logic              blank;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Prescaler, scan index, frame latch and blink timebase.
  always_comb begin
    tick     = (presc_q == P_LAST);
    presc_d  = tick ? '0 : presc_q + PW'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    if (tick) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        shadow_d = {minutes_tens, minutes_units,
                    seconds_tens, seconds_units};
      end
      if (bcnt_q == B_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  // Next display step, built from post-tick index, digits and phase.
  always_comb begin
    digit   = shadow_d[idx_d];
    blank   = blink_en & phase_d &
              (blink_sel ? ~idx_d[1] : idx_d[1]);
    anode_d = anode_q;
    seg_d   = seg_q;
    if (tick) begin
      unique case (idx_d)
        2'd0: anode_d = 4'b1110;
        2'd1: anode_d = 4'b1101;
        2'd2: anode_d = 4'b1011;
        2'd3: anode_d = 4'b0111;
      endcase
      seg_d = bcd_to_seg(digit);
      if (blank) begin
        anode_d = 4'b1111;
        seg_d   = 7'b1111111;
      end
    end
  end

  // State and output registers; reset darkens the display at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
      anode_q  <= 4'b1111;
      seg_q    <= 7'b1111111;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
    end
  end

  assign anode    = anode_q;
  assign segments = seg_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the 4-digit common-anode seven-segment display, directly downstream of the stopwatch digit split.
- Consumes four BCD digits: minutes tens/units and seconds tens/units.
- Scans one digit per refresh tick and drives active-low anode and segment lines.
- Latches digits once per frame so a digit never changes mid-frame, and blinks the selected field (minutes or seconds) while adjust mode is active.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit step (1 kHz step / 250 Hz frame at 100 MHz); must be >= 2.
- BLINK_TICKS, 250: refresh ticks per blink phase toggle (~2 Hz blink); must be >= 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- minutes_tens  in  4  BCD, shown on anode[3].
- minutes_units  in  4  BCD, shown on anode[2].
- seconds_tens  in  4  BCD, shown on anode[1].
- seconds_units  in  4  BCD, shown on anode[0].
- blink_en  in  1  1 = blink the selected field.
- blink_sel  in  1  0 = minutes pair (digits 3,2); 1 = seconds pair (digits 1,0).
- anode  out  4  active-low digit enables, one-hot-low when lit.
- segments  out  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - reset_n is asynchronous and active-low; assertion clears all state immediately, independent of clk.
- Reset values:
  - anode = 4'b1111, segments = 7'b1111111 (display dark).
  - Prescaler = 0, scan index = 0, blink counter = 0, blink phase = 0 (visible).
  - All four shadow digit registers = 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick is asserted for the single cycle when prescaler == REFRESH_DIV-1.
- Scan index:
  - 2-bit, advances 0->1->2->3->0 on each tick.
  - Index i selects anode[i] and its digit.
- Frame latch:
  - On a tick where index == 3 (i.e., wrapping to 0), all four inputs are captured into the shadow registers simultaneously.
  - Display always shows shadow values, never live inputs.
  - Input change becomes visible at the next frame start: worst case 4*REFRESH_DIV+1 cycles.
- Output register:
  - anode and segments are registered.
  - Both update in the same cycle, the cycle after tick, from the new index and shadow value.
  - They never change on non-tick cycles, except via reset.
- Decode, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Values 10-15 give 1111111 (blank); anode still asserted.
- Blink:
  - Blink counter advances on tick, counting 0..BLINK_TICKS-1.
  - On its wrap, blink phase toggles.
  - Counter and phase are free-running, independent of blink_en.
- Blanking:
  - When blink_en = 1 and phase = 1 and the scanned index is in the pair chosen by blink_sel, anode = 4'b1111 for that step.
  - Segments take don't-care in this case; drive 1111111.
  - blink_en and blink_sel are sampled live, not shadowed; changes take effect on the next output update.
- Simultaneous events:
  - Frame latch and blink toggle on the same tick: the new step uses the newly latched digit and the new phase.
- Reset mid-scan:
  - Display goes dark immediately.
  - After release, the first lit digit is index 1, REFRESH_DIV+1 cycles later, showing the reset shadow value 0.
  - Real digits appear after the first frame latch.
- Sizing:
  - Counter widths are ceil(log2(REFRESH_DIV)) and ceil(log2(BLINK_TICKS)), minimum 1 bit.
  - No arithmetic overflow is possible.

Test Plan:
- REFRESH_DIV=4, BLINK_TICKS=8. Reset low then release, inputs 1,2,3,4 (m_t..s_u) -> anode 1111 / segments 1111111 while reset low. First frame shows 0s. After the first frame latch the scan shows anode 1110 + 0011001 ('4'), then 1101 + 0110000, 1011 + 0100100, 0111 + 1111001, each held exactly 4 cycles.
- Change seconds_units 4->9 mid-frame while index = 1 -> digit 0 keeps '4' until the next latch, then shows 0010000. anode/segments never change on non-tick cycles.
- Input value 12 on minutes_units -> during index 2, anode = 1011 and segments = 1111111.
- blink_en=1, blink_sel=1 -> for 32 cycles (8 ticks) anodes 1110/1101 are lit. For the next 32 cycles, steps 0 and 1 show anode 1111 while steps 2 and 3 stay lit. blink_sel=0 blanks steps 2 and 3 instead.
- Deassert blink_en during the blank phase -> the next output update lights the digit normally.
- Assert reset_n low asynchronously between clock edges mid-frame -> outputs go dark without a clock edge. After release, counters restart from 0 as in scenario 1.
